lcd_hex_display: RTL and testbench
==================================

# lcd_hex_display

Character-LCD back end for the MiniAlu lab design. It consumes the 8-bit value the ALU's `LED` instruction latches onto its LED output bus and shows it as two ASCII hex digits at the top-left of a HD44780-compatible display in 4-bit write-only mode, as on the Spartan-3E starter board. It owns the full power-on initialisation sequence, the nibble-level bus timing, and a one-deep pending-value buffer, so the ALU never stalls.

## Interface
Parameters (all in Clock cycles):
- `INIT_WAIT`, 750000: power-on wait before the first nibble (15 ms at 50 MHz).
- `T_SU`, 2: RS/data setup before E rises.
- `T_EN`, 12: E high width.
- `T_GAP`, 50: wait between the upper and lower nibble of one byte.
- `T_CMD`, 2000: wait after every byte and after each init nibble.
- `T_CLR`, 82000: wait after the Clear Display command.

Ports:
- `Clock`, in, 1: sole clock; all state changes on rising edge.
- `Reset`, in, 1: asynchronous, active-low reset. Name kept per codebase; the polarity is fixed.
- `iData`, in, 8: value to display, normally the ALU LED bus.
- `iLoad`, in, 1: single-cycle strobe; capture `iData`.
- `oBusy`, out, 1: high when not in IDLE.
- `oLCD_E`, out, 1: LCD enable.
- `oLCD_RS`, out, 1: 0 = command, 1 = character data.
- `oLCD_RW`, out, 1: tied 0 (write only).
- `oLCD_Data`, out, 4: LCD data nibble (DB7..DB4).

## Operation
- Reset values: `oLCD_E`=0, `oLCD_RS`=0, `oLCD_RW`=0, `oLCD_Data`=0, `oBusy`=1, pending flag cleared, displayed-value register=0x00.
- States:
  - PWR_WAIT to INIT_NIB: 0x3, 0x3, 0x3, 0x2, each as a lone nibble with RS=0 and followed by `T_CMD`.
  - CONFIG: bytes 0x28, 0x06, 0x0C, 0x01, RS=0. Clear (0x01) is followed by `T_CLR`; the others by `T_CMD`.
  - IDLE, then WRITE: byte 0x80 (RS=0), then the high-digit char and low-digit char (RS=1).
  - Return to IDLE after WRITE.
- Byte transfer: upper nibble first, then `T_GAP`, then lower nibble, then the byte's post-wait.
- Hex conversion per nibble n: n ≤ 9 → 0x30+n; n ≥ 10 → 0x37+n, giving 'A'..'F' (uppercase).
- Load handling:
  - `iLoad` in IDLE captures `iData` and enters WRITE next cycle.
  - `iLoad` while busy (including during init) stores `iData` in the pending register; the last strobe wins.
  - On reaching IDLE with pending set: clear pending and start WRITE with the stored value. No IDLE cycle is spent, and `oBusy` stays 1.
  - A simultaneous IDLE entry and `iLoad` takes the new `iData`.
- Reset mid-operation: all outputs return to reset values immediately (E can drop mid-pulse), any pending value is discarded, and the full init restarts.

## Timing
- One nibble: RS/data driven with E=0 for `T_SU` cycles, then E=1 for `T_EN` cycles, then E=0. Data and RS are held unchanged through the following gap/wait.
- Cycle accounting, with the first cycle after `Reset` deasserts as cycle 0:
  - PWR_WAIT lasts `INIT_WAIT` cycles.
  - The first E rises at cycle `INIT_WAIT`+`T_SU`.
- WRITE latency from an IDLE `iLoad` to the rise of the first E pulse is 1+`T_SU` cycles.
- Full WRITE length is 3·(2·(`T_SU`+`T_EN`)+`T_GAP`+`T_CMD`) cycles.
- `oBusy` falls in the cycle IDLE is entered and rises in the cycle after an IDLE `iLoad`.
- All counters are wide enough for `INIT_WAIT`; the counter reloads on every state entry and never wraps.

## Configuration
- `LCD_SKIP_SAME_EN`:
  - Defined: an `iLoad` whose value equals the displayed-value register (last value written to the LCD) is dropped in IDLE and when promoted from pending. `oBusy` stays 0.
  - Undefined: every load triggers a WRITE.
- The displayed-value register is updated at WRITE start in both builds.

## Test plan
Bench parameters: `INIT_WAIT`=20, `T_SU`=2, `T_EN`=4, `T_GAP`=3, `T_CMD`=10, `T_CLR`=30.
- Release `Reset` → first E rise at cycle 22. Exactly 12 E pulses follow with nibbles 3,3,3,2,2,8,0,6,0,C,0,1 and RS=0 throughout. After that `oBusy`=0 and `oLCD_RW` is 0 at all times.
- IDLE, `iLoad` with 0x3C → nibbles 8,0 (RS=0), 3,3 then 4,3 (RS=1), first E rise 3 cycles after the strobe, `oBusy` high for exactly 3·(12+3+10)=75 cycles.
- Load 0xA5, then 0x07 and 0xE1 during that WRITE → after 0xA5 completes, one WRITE of 0xE1 ('E'=0x45, '1'=0x31). 0x07 is never sent, and `oBusy` shows no low cycle between the two WRITEs.
- Load 0x90, then 0x0F → chars 0x39,0x30, then 0x30,0x46.
- Assert `Reset` during the second E-high cycle of a char nibble, with a load pending → E is 0 in the same cycle. After release, the init sequence repeats from PWR_WAIT and the pending value is never written.
- Load 0x3C twice, each from IDLE → with `LCD_SKIP_SAME_EN`, the second produces no E pulse and `oBusy` stays 0; without it, a second identical 75-cycle WRITE occurs.

Source files
------------

// File: rtl/lcd_hex_display.sv
// HD44780 4-bit back end: runs power-on init, then shows an 8-bit value as two hex chars.
// Optional build macro LCD_SKIP_SAME_EN drops loads equal to the value already on screen.
module lcd_hex_display #(
  parameter int INIT_WAIT = 750000,
  parameter int T_SU      = 2,
  parameter int T_EN      = 12,
  parameter int T_GAP     = 50,
  parameter int T_CMD     = 2000,
  parameter int T_CLR     = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iLoad,
  output logic       oBusy,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data
);
  localparam int MAXA = (INIT_WAIT > T_CLR) ? INIT_WAIT : T_CLR;
  localparam int MAXB = (T_CMD > T_GAP) ? T_CMD : T_GAP;
  localparam int MAXC = (T_SU > T_EN) ? T_SU : T_EN;
  localparam int MAXD = (MAXA > MAXB) ? MAXA : MAXB;
  localparam int MAXT = (MAXD > MAXC) ? MAXD : MAXC;
  localparam int CW   = $clog2(MAXT + 1);
  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [2:0] {PWR_WAIT, INIT_NIB, CONFIG, IDLE, WRITE} state_t;
  typedef enum logic [1:0] {SETUP, PULSE, HOLD} phase_t;

  state_t     state, stateN;
  phase_t     phase, phaseN;
  cnt_t       cnt, cntN;
  logic [1:0] idx, idxN;
  logic       hi, hiN;
  logic       pend, pendN;
  logic [7:0] pendVal, pendValN, shown, shownN;
  logic [3:0] holdD;
  logic       holdRs;
  logic [7:0] curByte, cand;
  logic [3:0] curNib;
  logic       curRs, active, goIdle, candVld, dropSame;

  function automatic logic [7:0] hexChar(input logic [3:0] n);
    return (n <= 4'd9) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  assign active = (state == INIT_NIB) || (state == CONFIG) || (state == WRITE);

  always_comb begin
    curByte = 8'h00;
    curRs   = 1'b0;
    unique case (state)
      INIT_NIB: curByte = (idx == 2'd3) ? 8'h20 : 8'h30;
      CONFIG: begin
        unique case (idx)
          2'd0:    curByte = 8'h28;
          2'd1:    curByte = 8'h06;
          2'd2:    curByte = 8'h0C;
          default: curByte = 8'h01;
        endcase
      end
      WRITE: begin
        unique case (idx)
          2'd0:    curByte = 8'h80;
          2'd1:    begin curByte = hexChar(shown[7:4]); curRs = 1'b1; end
          default: begin curByte = hexChar(shown[3:0]); curRs = 1'b1; end
        endcase
      end
      default: ;
    endcase
    curNib = hi ? curByte[7:4] : curByte[3:0];
  end

  // A strobe in the same cycle as IDLE entry beats the pending value.
  assign cand    = iLoad ? iData : pendVal;
  assign candVld = iLoad | pend;
`ifdef LCD_SKIP_SAME_EN
  assign dropSame = (cand == shown);
`else
  assign dropSame = 1'b0;
`endif

  always_comb begin
    stateN   = state;
    phaseN   = phase;
    cntN     = cnt;
    idxN     = idx;
    hiN      = hi;
    pendN    = pend;
    pendValN = pendVal;
    shownN   = shown;
    goIdle   = 1'b0;
    if (iLoad && state != IDLE) begin
      pendN    = 1'b1;
      pendValN = iData;
    end
    if (state == PWR_WAIT) begin
      if (cnt == '0) begin
        stateN = INIT_NIB;
        phaseN = SETUP;
        cntN   = cnt_t'(T_SU - 1);
        idxN   = 2'd0;
        hiN    = 1'b1;
      end else cntN = cnt - 1'b1;
    end else if (active) begin
      if (cnt != '0) cntN = cnt - 1'b1;
      else begin
        unique case (phase)
          SETUP: begin
            phaseN = PULSE;
            cntN   = cnt_t'(T_EN - 1);
          end
          PULSE: begin
            phaseN = HOLD;
            if (hi && state != INIT_NIB)              cntN = cnt_t'(T_GAP - 1);
            else if (state == CONFIG && idx == 2'd3) cntN = cnt_t'(T_CLR - 1);
            else                                      cntN = cnt_t'(T_CMD - 1);
          end
          default: begin
            phaseN = SETUP;
            cntN   = cnt_t'(T_SU - 1);
            hiN    = 1'b1;
            if (hi && state != INIT_NIB) hiN = 1'b0;
            else if (state == INIT_NIB) begin
              idxN = (idx == 2'd3) ? 2'd0 : idx + 2'd1;
              if (idx == 2'd3) stateN = CONFIG;
            end else if ((state == CONFIG && idx != 2'd3) || (state == WRITE && idx != 2'd2))
              idxN = idx + 2'd1;
            else goIdle = 1'b1;
          end
        endcase
      end
    end
    // IDLE entry and IDLE itself share one decision so a queued value starts with no idle cycle.
    if (state == IDLE || goIdle) begin
      pendN  = 1'b0;
      stateN = IDLE;
      phaseN = SETUP;
      if (candVld && !dropSame) begin
        stateN = WRITE;
        cntN   = cnt_t'(T_SU - 1);
        idxN   = 2'd0;
        hiN    = 1'b1;
        shownN = cand;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= PWR_WAIT;
      phase   <= SETUP;
      cnt     <= cnt_t'(INIT_WAIT - 1);
      idx     <= 2'd0;
      hi      <= 1'b1;
      pend    <= 1'b0;
      pendVal <= 8'h00;
      shown   <= 8'h00;
      holdD   <= 4'h0;
      holdRs  <= 1'b0;
    end else begin
      state   <= stateN;
      phase   <= phaseN;
      cnt     <= cntN;
      idx     <= idxN;
      hi      <= hiN;
      pend    <= pendN;
      pendVal <= pendValN;
      shown   <= shownN;
      holdD   <= oLCD_Data;
      holdRs  <= oLCD_RS;
    end
  end

  // Bus keeps the last nibble/RS while idle so the LCD sees stable lines.
  assign oLCD_E    = active && (phase == PULSE);
  assign oLCD_Data = active ? curNib : holdD;
  assign oLCD_RS   = active ? curRs : holdRs;
  assign oLCD_RW   = 1'b0;
  assign oBusy     = (state != IDLE);
endmodule

// File: tb/tb_lcd_hex_display.sv
// Directed bench for lcd_hex_display: init sequence, hex writes, pending handling, reset abort.
module tb_lcd_hex_display;
  logic       Clock = 1'b0;
  logic       Reset, iLoad;
  logic [7:0] iData;
  logic       oBusy, oLCD_E, oLCD_RS, oLCD_RW;
  logic [3:0] oLCD_Data;

  lcd_hex_display #(
    .INIT_WAIT(20), .T_SU(2), .T_EN(4), .T_GAP(3), .T_CMD(10), .T_CLR(30)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iData(iData), .iLoad(iLoad), .oBusy(oBusy),
    .oLCD_E(oLCD_E), .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW), .oLCD_Data(oLCD_Data)
  );

  typedef struct { logic [3:0] nib; logic rs; int cyc; } ev_t;
  ev_t        evQ[$];
  logic [4:0] expQ[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic       prevE = 1'b0;
  logic       rwBad = 1'b0;
  int         rel, k;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (oLCD_E && !prevE) evQ.push_back(ev_t'{oLCD_Data, oLCD_RS, cyc});
    prevE <= oLCD_E;
    if (oLCD_RW !== 1'b0) rwBad <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    iLoad = 1'b1;
    iData = v;
    step();
    iLoad = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (oBusy && n < 1000) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, {31'b0, oBusy}, 0);
  endtask

  task automatic checkEvents(input string tag);
    chk({tag, "_count"}, evQ.size(), expQ.size());
    for (int i = 0; i < evQ.size() && i < expQ.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), {27'b0, evQ[i].rs, evQ[i].nib}, {27'b0, expQ[i]});
  endtask

  initial begin
    Reset = 1'b0;
    iLoad = 1'b0;
    iData = 8'h00;
    repeat (3) step();
    chk("rst_e", {31'b0, oLCD_E}, 0);
    chk("rst_rs", {31'b0, oLCD_RS}, 0);
    chk("rst_data", {28'b0, oLCD_Data}, 0);
    chk("rst_busy", {31'b0, oBusy}, 1);

    // Power-on init
    Reset = 1'b1;
    rel = cyc;
    evQ.delete();
    waitIdle("init");
    chk("init_idle_cyc", cyc - rel, 204);
    if (evQ.size() > 0) chk("init_first_e", evQ[0].cyc - rel, 22);
    expQ = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};
    checkEvents("init");

    // Single write of 0x3C from IDLE
    evQ.delete();
    k = cyc;
    load(8'h3C);
    waitIdle("w3c");
    chk("w3c_busy_len", cyc - (k + 1), 75);
    if (evQ.size() > 0) chk("w3c_first_e", evQ[0].cyc - k, 3);
    expQ = '{5'h08, 5'h00, 5'h13, 5'h13, 5'h14, 5'h13};
    checkEvents("w3c");

    // 0xA5, then 0x07 and 0xE1 while busy: last strobe wins, no idle gap
    evQ.delete();
    k = cyc;
    load(8'hA5);
    repeat (5) step();
    load(8'h07);
    repeat (10) step();
    load(8'hE1);
    waitIdle("pend");
    chk("pend_busy_len", cyc - (k + 1), 150);
    expQ = '{5'h08, 5'h00, 5'h14, 5'h11, 5'h13, 5'h15,
             5'h08, 5'h00, 5'h14, 5'h15, 5'h13, 5'h11};
    checkEvents("pend");

    // 0x90 then 0x0F
    evQ.delete();
    load(8'h90);
    repeat (5) step();
    load(8'h0F);
    waitIdle("w90");
    expQ = '{5'h08, 5'h00, 5'h13, 5'h19, 5'h13, 5'h10,
             5'h08, 5'h00, 5'h13, 5'h10, 5'h14, 5'h16};
    checkEvents("w90");

    // Reset during the second E-high cycle of the first char nibble, with a load pending
    k = cyc;
    load(8'h55);
    repeat (8) step();
    load(8'h77);
    while (cyc < k + 29) step();
    chk("abort_e_pre", {31'b0, oLCD_E}, 1);
    Reset = 1'b0;
    #1;
    chk("abort_e", {31'b0, oLCD_E}, 0);
    chk("abort_rs", {31'b0, oLCD_RS}, 0);
    chk("abort_data", {28'b0, oLCD_Data}, 0);
    chk("abort_busy", {31'b0, oBusy}, 1);
    repeat (3) step();
    Reset = 1'b1;
    rel = cyc;
    evQ.delete();
    waitIdle("reinit");
    chk("reinit_idle_cyc", cyc - rel, 204);
    if (evQ.size() > 0) chk("reinit_first_e", evQ[0].cyc - rel, 22);
    expQ = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};
    checkEvents("reinit");
    repeat (30) step();
    chk("reinit_no_pend_busy", {31'b0, oBusy}, 0);
    chk("reinit_no_pend_ev", evQ.size(), 12);

    // Same value twice from IDLE
    evQ.delete();
    load(8'h3C);
    waitIdle("same1");
    evQ.delete();
    k = cyc;
    load(8'h3C);
`ifdef LCD_SKIP_SAME_EN
    chk("same2_busy", {31'b0, oBusy}, 0);
    repeat (10) step();
    chk("same2_ev", evQ.size(), 0);
`else
    waitIdle("same2");
    chk("same2_busy_len", cyc - (k + 1), 75);
    expQ = '{5'h08, 5'h00, 5'h13, 5'h13, 5'h14, 5'h13};
    checkEvents("same2");
`endif

    chk("rw_low", {31'b0, rwBad}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
